// File: rtl/nes_line_feeder.sv
// Scanline fetcher: streams one framebuffer line per request into the video FIFO,
// honouring FIFO back-pressure and optionally substituting a blank colour.
module nes_line_feeder #(
  parameter int          LINE_W     = 256,
  parameter int          LINE_H     = 240,
  parameter logic [5:0]  BLANK_CODE = 6'h0F
) (
  input  logic        cpu_clk,
  input  logic        reset,
  input  logic        line_req,
  input  logic        fifo_afull,
  input  logic        blank,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  output logic [5:0]  c_code_cpu,
  output logic        cpu_write,
  output logic        busy,
  output logic [7:0]  line_y,
  output logic        frame_start
);

  localparam int XW = (LINE_W > 1) ? $clog2(LINE_W) : 1;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } state_t;

  state_t        state, state_next;
  logic [XW-1:0] x, x_next;
  logic          pending;
  logic          line_blank;
  logic [5:0]    code_hold;
  logic [5:0]    code_now;
  logic          start;
  logic          x_last;

  // A line starts in the IDLE cycle that sees a request (live or remembered);
  // qualifying with reset keeps busy/frame_start low while reset is held.
  assign start  = (state == IDLE) && (line_req || pending) && reset;
  assign x_last = (x == XW'(LINE_W - 1));

  always_comb begin
    state_next = state;
    x_next     = x;
    mem_rd     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = FETCH;
          x_next     = '0;
        end
      end
      FETCH: begin
        if (!fifo_afull) begin
          mem_rd = 1'b1;
          x_next = x + XW'(1);
          if (x_last) state_next = DRAIN;
        end
      end
      DRAIN: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge cpu_clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      x          <= '0;
      pending    <= 1'b0;
      line_blank <= 1'b0;
      line_y     <= '0;
      cpu_write  <= 1'b0;
      code_hold  <= '0;
    end else begin
      state     <= state_next;
      x         <= x_next;
      cpu_write <= mem_rd;
      if (start) begin
        pending    <= 1'b0;
        line_blank <= blank;
      end else if (line_req && (state != IDLE)) begin
        pending <= 1'b1;
      end
      if (state == DRAIN) begin
        line_y <= (line_y == 8'(LINE_H - 1)) ? 8'd0 : line_y + 8'd1;
      end
      if (cpu_write) code_hold <= code_now;
    end
  end

  // Read data arrives in the push cycle itself, so the pushed code is taken
  // straight from the bus and only remembered for the idle cycles after it.
  assign code_now    = line_blank ? BLANK_CODE : mem_rdata[5:0];
  assign c_code_cpu  = cpu_write ? code_now : code_hold;
  assign mem_addr    = {line_y, 8'(x)};
  assign busy        = (state != IDLE) || start;
  assign frame_start = start && (line_y == 8'd0);

endmodule
